// File: rtl/instr_feeder_pkg.sv
// Shared constants for the instruction feeder: HALT sentinel, FSM encoding and
// cpu opcode fields used to assemble small programs.
package instr_feeder_pkg;

    localparam logic [15:0] HALT_INSTR = 16'h0000;

    localparam logic [4:0] MOV_IMM = 5'b11010;
    localparam logic [4:0] MOV     = 5'b11000;
    localparam logic [4:0] ADD     = 5'b10100;
    localparam logic [4:0] CMP     = 5'b10101;
    localparam logic [4:0] AND     = 5'b10110;
    localparam logic [4:0] MVN     = 5'b10111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StWaitAck,
        StWaitDone,
        StDone,
        StErr
    } feeder_state_e;

    function automatic logic [15:0] enc_mov_imm(input logic [2:0] rd, input logic [7:0] imm);
        return {MOV_IMM, rd, imm};
    endfunction

    // Register-form ALU/move word: op | rn | rd | shift | rm
    function automatic logic [15:0] enc_alu(input logic [4:0] op, input logic [2:0] rn,
                                            input logic [2:0] rd, input logic [1:0] sh,
                                            input logic [2:0] rm);
        return {op, rn, rd, sh, rm};
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Host/cpu-facing bundle of the instruction feeder. master = host and cpu side,
// slave = the feeder itself.
interface instr_feeder_if #(
    parameter int unsigned AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          go;
    logic          w;
    logic [15:0]   in;
    logic          load;
    logic          s;
    logic [AW-1:0] pc;
    logic [AW:0]   retired;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output prog_we, prog_addr, prog_data, go, w,
        input  in, load, s, pc, retired, busy, done, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, go, w,
        output in, load, s, pc, retired, busy, done, err
    );

endinterface

// File: rtl/instr_feeder_rom_ram.sv
// DEPTH x 16 program store: one synchronous write port, one synchronous read
// port whose output register doubles as the feeder's registered instruction.
module feeder_rom_ram
    import instr_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= HALT_INSTR;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// Runs a stored program into the cpu's in/load/s/w handshake one instruction
// at a time, stopping on HALT, on the last word, or on an ack timeout.
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           reset,
    instr_feeder_if.slave  bus
);

    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    feeder_state_e state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   retired_q, retired_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mem_we;
    logic          mem_re;
    logic [15:0]   instr;
    logic          load_pulse;
    logic          start_pulse;
    logic          busy_flag;
    logic          done_flag;
    logic          err_flag;

    feeder_rom_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .re    (mem_re),
        .raddr (pc_q),
        .rdata (instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            retired_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.go) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: state_d = (instr == HALT_INSTR) ? StDone : StStart;
            StStart: begin
                // Counter holds cycles elapsed since s, so the s cycle counts as one.
                cnt_d   = CW'(1);
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (!bus.w) begin
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= CW'(ACK_TIMEOUT - 1)) begin
                        state_d = StErr;
                    end
                end
            end
            StWaitDone: begin
                if (bus.w) begin
                    retired_d = retired_q + 1'b1;
                    if (pc_q == AW'(DEPTH - 1)) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_pulse  = (state_q == StLoad) && (instr != HALT_INSTR);
        start_pulse = (state_q == StStart);
        done_flag   = (state_q == StDone);
        err_flag    = (state_q == StErr);
        busy_flag   = !((state_q == StIdle) || done_flag || err_flag);
        mem_re      = (state_q == StFetch);
        mem_we      = bus.prog_we && !busy_flag;
    end

    assign bus.in      = instr;
    assign bus.load    = load_pulse;
    assign bus.s       = start_pulse;
    assign bus.pc      = pc_q;
    assign bus.retired = retired_q;
    assign bus.busy    = busy_flag;
    assign bus.done    = done_flag;
    assign bus.err     = err_flag;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a small behavioural cpu answers the handshake and
// executes MOV_IMM/MOV/ADD so program results can be checked in registers.
module tb_instr_feeder;
    import instr_feeder_pkg::*;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned AW          = 4;
    localparam int unsigned ACK_TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_feeder_if #(.AW(AW)) bus ();

    instr_feeder #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural cpu: drops w for three cycles per instruction, then executes.
    logic        w_model;
    logic        cpu_dead = 1'b0;
    logic [15:0] regs [8];
    logic [15:0] cur;
    int unsigned busy_cnt;

    assign bus.w = cpu_dead ? 1'b1 : w_model;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            w_model  <= 1'b1;
            busy_cnt <= 0;
            cur      <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (w_model && bus.s) begin
            w_model  <= 1'b0;
            busy_cnt <= 2;
            cur      <= bus.in;
        end else if (!w_model) begin
            if (busy_cnt == 0) begin
                case (cur[15:11])
                    MOV_IMM: regs[cur[10:8]] <= {8'h00, cur[7:0]};
                    MOV:     regs[cur[7:5]]  <= regs[cur[2:0]];
                    ADD:     regs[cur[7:5]]  <= regs[cur[10:8]] + regs[cur[2:0]];
                    default: ;
                endcase
                w_model <= 1'b1;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Handshake monitor: s must follow a load by one cycle, with w high.
    int   n_load = 0;
    int   n_s = 0;
    logic prev_load = 1'b0;

    always @(negedge clk) begin
        if (bus.s) begin
            check("s_follows_load", prev_load, 1);
            check("s_while_w_high", bus.w, 1);
            n_s++;
        end
        if (bus.load || bus.s) check("load_s_exclusive", bus.load & bus.s, 0);
        if (bus.load) n_load++;
        prev_load <= bus.load;
    end

    task automatic write_word(input int a, input logic [15:0] d);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(a);
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(bus.done || bus.err) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, 32'(bus.done || bus.err), 1);
    endtask

    task automatic wait_s(input string name);
        int n = 0;
        while (!bus.s && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_s_seen"}, 32'(bus.s), 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] i0;
        logic [15:0] i1;
        int          exp_ret;
        int          reg_idx;
        logic [15:0] reg_val;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int k;
        int n;

        vecs[0] = '{enc_mov_imm(3'd0, 8'h12), HALT_INSTR, 1, 0, 16'h0012};
        vecs[1] = '{enc_mov_imm(3'd1, 8'h05), HALT_INSTR, 1, 1, 16'h0005};
        vecs[2] = '{enc_alu(ADD, 3'd0, 3'd2, 2'b00, 3'd1), HALT_INSTR, 1, 2, 16'h0017};
        vecs[3] = '{enc_mov_imm(3'd4, 8'h7F), enc_alu(MOV, 3'd0, 3'd5, 2'b00, 3'd4), 2, 5,
                    16'h007F};
        vecs[4] = '{HALT_INSTR, enc_mov_imm(3'd6, 8'h55), 0, 6, 16'h0000};

        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.go        = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in", bus.in, 0);
        check("rst_load", bus.load, 0);
        check("rst_s", bus.s, 0);
        check("rst_pc", bus.pc, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b0;

        // Reference program: R0=0x69, R1=4, R2=R0+R1.
        write_word(0, 16'b11010_000_0110_1001);
        write_word(1, 16'b11010_001_0000_0100);
        write_word(2, 16'b10100_000_010_00_001);
        write_word(3, HALT_INSTR);
        n_load = 0;
        n_s = 0;
        pulse_go();
        check("a_busy", bus.busy, 1);
        wait_end("a");
        check("a_done", bus.done, 1);
        check("a_err", bus.err, 0);
        check("a_retired", bus.retired, 3);
        check("a_pc", bus.pc, 3);
        check("a_r0", regs[0], 16'h0069);
        check("a_r1", regs[1], 16'h0004);
        check("a_r2", regs[2], 16'h006D);
        check("a_loads", n_load, 3);
        check("a_starts", n_s, 3);

        for (int v = 0; v < 5; v++) begin
            write_word(0, vecs[v].i0);
            write_word(1, vecs[v].i1);
            write_word(2, HALT_INSTR);
            n_load = 0;
            n_s = 0;
            pulse_go();
            wait_end($sformatf("vec%0d", v));
            check($sformatf("vec%0d_done", v), bus.done, 1);
            check($sformatf("vec%0d_err", v), bus.err, 0);
            check($sformatf("vec%0d_retired", v), bus.retired, vecs[v].exp_ret);
            check($sformatf("vec%0d_loads", v), n_load, vecs[v].exp_ret);
            check($sformatf("vec%0d_starts", v), n_s, vecs[v].exp_ret);
            check($sformatf("vec%0d_reg", v), regs[vecs[v].reg_idx], vecs[v].reg_val);
        end

        // Full memory with no HALT: stops at the last word, no wrap.
        for (int a = 0; a < 16; a++) write_word(a, enc_mov_imm(3'd3, 8'(a)));
        pulse_go();
        wait_end("full");
        check("full_done", bus.done, 1);
        check("full_retired", bus.retired, 16);
        check("full_pc", bus.pc, 15);
        check("full_r3", regs[3], 16'h000F);
        repeat (3) @(negedge clk);
        check("full_done_held", bus.done, 1);
        check("full_retired_held", bus.retired, 16);

        // Unresponsive cpu: err exactly ACK_TIMEOUT cycles after s.
        write_word(0, enc_mov_imm(3'd7, 8'h01));
        write_word(1, HALT_INSTR);
        cpu_dead = 1'b1;
        pulse_go();
        n = 0;
        while (!bus.s && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_s_seen", bus.s, 1);
        k = 0;
        while (!bus.err && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("to_latency", k, ACK_TIMEOUT);
        check("to_err", bus.err, 1);
        check("to_busy", bus.busy, 0);
        check("to_done", bus.done, 0);
        cpu_dead = 1'b0;
        repeat (4) @(negedge clk);
        check("to_err_held", bus.err, 1);
        pulse_go();
        check("to_err_cleared", bus.err, 0);
        wait_end("to_rerun");
        check("to_rerun_done", bus.done, 1);
        check("to_rerun_retired", bus.retired, 1);

        // Write while busy is dropped; the same write alongside go lands.
        write_word(0, enc_mov_imm(3'd6, 8'h11));
        write_word(1, enc_mov_imm(3'd7, 8'h22));
        write_word(2, HALT_INSTR);
        write_word(3, HALT_INSTR);
        pulse_go();
        @(negedge clk);
        check("wb_busy_at_write", bus.busy, 1);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(2);
        bus.prog_data = enc_mov_imm(3'd6, 8'h33);
        @(negedge clk);
        bus.prog_we = 1'b0;
        wait_end("wb");
        check("wb_retired", bus.retired, 2);
        check("wb_r6", regs[6], 16'h0011);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(2);
        bus.prog_data = enc_mov_imm(3'd6, 8'h33);
        bus.go        = 1'b1;
        @(negedge clk);
        bus.prog_we = 1'b0;
        bus.go      = 1'b0;
        wait_end("wi");
        check("wi_retired", bus.retired, 3);
        check("wi_r6", regs[6], 16'h0033);

        // Reset during WAIT_DONE of the second instruction clears outputs at once.
        pulse_go();
        wait_s("rs1");
        wait_s("rs2");
        n = 0;
        while (bus.w && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rs_w_low", bus.w, 0);
        @(negedge clk);
        check("rs_pc_before", bus.pc, 1);
        #1 reset = 1'b1;
        #1;
        check("rs_in", bus.in, 0);
        check("rs_load", bus.load, 0);
        check("rs_s", bus.s, 0);
        check("rs_pc", bus.pc, 0);
        check("rs_retired", bus.retired, 0);
        check("rs_busy", bus.busy, 0);
        check("rs_done", bus.done, 0);
        check("rs_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b0;
        pulse_go();
        check("rs_rerun_pc", bus.pc, 0);
        check("rs_rerun_busy", bus.busy, 1);
        wait_end("rs_rerun");
        check("rs_rerun_done", bus.done, 1);
        check("rs_rerun_retired", bus.retired, 3);
        check("rs_rerun_r6", regs[6], 16'h0033);
        check("rs_rerun_r7", regs[7], 16'h0022);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
